// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2^BPC restoring integer divider (DIV/DIVU/REM/REMU)
//
// Purpose: multi-cycle divider for the M-extension path with RISC-V corner-case
// semantics (divide by zero, signed overflow) and optional leading-zero early-out.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, flush            accept request when ready; abort any operation in flight
//   op[1:0]                 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend, divisor       operands, sampled on accept only
//   ready                   high in IDLE
//   valid                   one-cycle pulse when the outputs below are new
//   result                  quotient (op[1]==0) or remainder (op[1]==1)
//   quotient, remainder     both results of the last completed operation
//   div_by_zero, overflow   corner-case flags of the last completed operation
module div_iter #(
  parameter int XLEN      = 32,
  parameter int BPC       = 1,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int NSTEP = XLEN / BPC;
  localparam int CW    = $clog2(NSTEP + 1);

  if ((XLEN % BPC) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_cfg
    $error("div_iter: BPC must be 1, 2 or 4 and divide XLEN");
  end

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIVIDE, S_FINISH} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            negd_q, negd_d, negs_q, negs_d;
  logic [XLEN-1:0] aq_q, aq_d;          // shifting dividend in, quotient bits in at the bottom
  logic [XLEN:0]   r_q, r_d, bm_q, bm_d;
  logic [CW-1:0]   cnt_q, cnt_d, iter_q, iter_d;
  logic            div0_q, div0_d, ovf_q, ovf_d;
  logic            valid_q, valid_d, dz_q, dz_d, ov_q, ov_d;
  logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d, res_q, res_d;

  logic [XLEN-1:0] amag, bmag, qfin, rfin;
  logic [XLEN-1:0] aq_t;
  logic [XLEN:0]   r_t, t_t;
  logic            qb;
  int              lz, skip;

  function automatic int clz(input logic [XLEN-1:0] v);
    int n;
    n = XLEN;
    for (int i = 0; i < XLEN; i++) begin
      if (v[i]) n = XLEN - 1 - i;
    end
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    negd_d  = negd_q;
    negs_d  = negs_q;
    aq_d    = aq_q;
    r_d     = r_q;
    bm_d    = bm_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    dz_d    = dz_q;
    ov_d    = ov_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    res_d   = res_q;
    // Magnitudes fit XLEN bits unsigned: |INT_MIN| = 2^(XLEN-1).
    amag    = negd_q ? (~a_q + 1'b1) : a_q;
    bmag    = negs_q ? (~b_q + 1'b1) : b_q;
    lz      = clz(amag);
    skip    = EARLY_OUT ? (lz / BPC) * BPC : 0;
    qfin    = '0;
    rfin    = '0;
    aq_t    = aq_q;
    r_t     = r_q;
    t_t     = '0;
    qb      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          a_d     = dividend;
          b_d     = divisor;
          negd_d  = ~op[0] & dividend[XLEN-1];
          negs_d  = ~op[0] & divisor[XLEN-1];
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        bm_d   = {1'b0, bmag};
        aq_d   = amag << skip;
        r_d    = '0;
        cnt_d  = '0;
        iter_d = CW'((XLEN - skip) / BPC);
        div0_d = (b_q == '0);
        ovf_d  = ~op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
        if (div0_d || ovf_d || iter_d == '0) state_d = S_FINISH;
        else                                 state_d = S_DIVIDE;
      end
      S_DIVIDE: begin
        // Partial remainder stays below the divisor, so it never goes negative
        // and the top bit of the trial subtraction is a clean borrow flag.
        for (int i = 0; i < BPC; i++) begin
          r_t  = {r_t[XLEN-1:0], aq_t[XLEN-1]};
          t_t  = r_t - bm_q;
          qb   = ~t_t[XLEN];
          if (qb) r_t = t_t;
          aq_t = {aq_t[XLEN-2:0], qb};
        end
        r_d   = r_t;
        aq_d  = aq_t;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == iter_q) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (div0_q) begin
          qfin = '1;
          rfin = a_q;
        end else if (ovf_q) begin
          qfin = {1'b1, {(XLEN-1){1'b0}}};
          rfin = '0;
        end else begin
          qfin = (negd_q ^ negs_q) ? (~aq_q + 1'b1) : aq_q;
          rfin = negd_q ? (~r_q[XLEN-1:0] + 1'b1) : r_q[XLEN-1:0];
        end
        quot_d  = qfin;
        rem_d   = rfin;
        res_d   = op_q[1] ? rfin : qfin;
        dz_d    = div0_q;
        ov_d    = ovf_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: drop the operation and leave the visible outputs untouched.
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      res_d   = res_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      negd_q  <= 1'b0;
      negs_q  <= 1'b0;
      aq_q    <= '0;
      r_q     <= '0;
      bm_q    <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      negd_q  <= negd_d;
      negs_q  <= negs_d;
      aq_q    <= aq_d;
      r_q     <= r_d;
      bm_q    <= bm_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign valid       = valid_q;
  assign result      = res_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter across BPC/EARLY_OUT configurations
module tb_div_iter;

  localparam int ND = 4;
  localparam logic [31:0] IMIN = 32'h8000_0000;

  function automatic int cfg_bpc(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 1;
  endfunction
  function automatic bit cfg_eo(input int g);
    return (g == 0) || (g == 2);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;

  logic        ready_o [ND];
  logic        valid_o [ND];
  logic        dz_o    [ND];
  logic        ov_o    [ND];
  logic [31:0] res_o   [ND];
  logic [31:0] q_o     [ND];
  logic [31:0] r_o     [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int GB = cfg_bpc(g);
    localparam bit GE = cfg_eo(g);
    div_iter #(.XLEN(32), .BPC(GB), .EARLY_OUT(GE)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
      .dividend(dividend), .divisor(divisor),
      .ready(ready_o[g]), .valid(valid_o[g]), .result(res_o[g]),
      .quotient(q_o[g]), .remainder(r_o[g]),
      .div_by_zero(dz_o[g]), .overflow(ov_o[g])
    );
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, q, r;
    logic        dz, ov;
  } vec_t;

  vec_t vecs [15];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d act=0x%08h exp=0x%08h", name, g, act, exp);
    end
  endtask

  function automatic int clz32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int exp_lat(input int g, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int sk;
    if (b == 0 || (!o[0] && a == IMIN && b == 32'hFFFF_FFFF)) return 2;
    m  = (!o[0] && a[31]) ? -a : a;
    sk = cfg_eo(g) ? (clz32(m) / cfg_bpc(g)) * cfg_bpc(g) : 0;
    return 2 + (32 - sk) / cfg_bpc(g);
  endfunction

  function automatic vec_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint sa, sb, qq, rr;
    v.op = o; v.a = a; v.b = b; v.dz = 1'b0; v.ov = 1'b0;
    if (b == 0) begin
      v.q = '1; v.r = a; v.dz = 1'b1;
    end else if (!o[0] && a == IMIN && b == 32'hFFFF_FFFF) begin
      v.q = IMIN; v.r = 0; v.ov = 1'b1;
    end else if (!o[0]) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      qq = sa / sb; rr = sa % sb;
      v.q = qq[31:0]; v.r = rr[31:0];
    end else begin
      v.q = a / b; v.r = a % b;
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string name);
    bit got [ND];
    int ngot;
    for (int g = 0; g < ND; g++) got[g] = 1'b0;
    ngot = 0;
    @(negedge clk);
    for (int g = 0; g < ND; g++) chk({name, " ready"}, g, 32'(ready_o[g]), 32'd1);
    start = 1'b1; op = v.op; dividend = v.a; divisor = v.b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = ~v.a; divisor = ~v.b;
    for (int k = 0; k < 60 && ngot < ND; k++) begin
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
        if (!got[g] && valid_o[g]) begin
          got[g] = 1'b1;
          ngot++;
          chk({name, " q"},   g, q_o[g], v.q);
          chk({name, " r"},   g, r_o[g], v.r);
          chk({name, " res"}, g, res_o[g], v.op[1] ? v.r : v.q);
          chk({name, " dz"},  g, 32'(dz_o[g]), 32'(v.dz));
          chk({name, " ov"},  g, 32'(ov_o[g]), 32'(v.ov));
          chk({name, " lat"}, g, k, exp_lat(g, v.op, v.a, v.b));
        end
      end
    end
    for (int g = 0; g < ND; g++) if (!got[g]) chk({name, " timeout"}, g, 32'd0, 32'd1);
  endtask

  task automatic count_valid(input int n, output int cnt [ND]);
    for (int g = 0; g < ND; g++) cnt[g] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int g = 0; g < ND; g++) if (valid_o[g]) cnt[g]++;
    end
  endtask

  logic [31:0] pool [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2, 32'h3, 32'h10};
  int cnt [ND];
  logic [31:0] ra, rb;
  logic [1:0]  ro;

  initial begin
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[2]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0};
    vecs[3]  = '{2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          32'd0,          1'b0, 1'b0};
    vecs[4]  = '{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1'b0};
    vecs[5]  = '{2'b00, IMIN,           32'hFFFF_FFFF,  IMIN,           32'd0,          1'b0, 1'b1};
    vecs[6]  = '{2'b01, IMIN,           32'hFFFF_FFFF,  32'd0,          IMIN,           1'b0, 1'b0};
    vecs[7]  = '{2'b11, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0, 1'b0};
    vecs[8]  = '{2'b00, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 1'b0};
    vecs[9]  = '{2'b00, IMIN,           32'd1,          IMIN,           32'd0,          1'b0, 1'b0};
    vecs[10] = '{2'b10, IMIN,           32'd3,          32'hD555_5556,  32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[11] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0};
    vecs[12] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0};
    vecs[13] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
    vecs[14] = '{2'b11, 32'd123456789,  32'd1000,       32'd123456,     32'd789,        1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    for (int g = 0; g < ND; g++) begin
      chk("rst ready", g, 32'(ready_o[g]), 32'd1);
      chk("rst valid", g, 32'(valid_o[g]), 32'd0);
      chk("rst q", g, q_o[g], 32'd0);
      chk("rst r", g, r_o[g], 32'd0);
      chk("rst res", g, res_o[g], 32'd0);
      chk("rst flags", g, {30'd0, dz_o[g], ov_o[g]}, 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      rb = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : ($urandom >> $urandom_range(0, 31));
      ro = 2'($urandom_range(0, 3));
      run_op(model(ro, ra, rb), "rand");
    end

    // Flush mid-DIVIDE, then a fresh DIVU 9/3
    run_op(vecs[0], "pre_flush");
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    for (int g = 0; g < ND; g++) chk("flush ready", g, 32'(ready_o[g]), 32'd1);
    count_valid(40, cnt);
    for (int g = 0; g < ND; g++) begin
      chk("flush no valid", g, cnt[g], 0);
      chk("flush hold q", g, q_o[g], 32'd14);
    end
    run_op('{2'b01, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0}, "post_flush");

    // Flush on the FINISH cycle of a divide-by-zero
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd5; divisor = 32'd0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    count_valid(10, cnt);
    for (int g = 0; g < ND; g++) begin
      chk("finflush no valid", g, cnt[g], 0);
      chk("finflush hold q", g, q_o[g], 32'd3);
      chk("finflush hold dz", g, 32'(dz_o[g]), 32'd0);
    end

    // start together with flush in IDLE is not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    for (int g = 0; g < ND; g++) chk("idle flush ready", g, 32'(ready_o[g]), 32'd1);

    // start held high: back-to-back accepts on each valid cycle
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'h1234_5678; divisor = 32'd0;
    for (int g = 0; g < ND; g++) cnt[g] = 0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (k == 11) start = 1'b0;
      for (int g = 0; g < ND; g++) if (valid_o[g]) cnt[g]++;
    end
    for (int g = 0; g < ND; g++) begin
      chk("b2b valids", g, cnt[g], 4);
      chk("b2b q", g, q_o[g], 32'hFFFF_FFFF);
      chk("b2b dz", g, 32'(dz_o[g]), 32'd1);
    end

    // Asynchronous reset mid-DIVIDE
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int g = 0; g < ND; g++) begin
      chk("async q", g, q_o[g], 32'd0);
      chk("async r", g, r_o[g], 32'd0);
      chk("async res", g, res_o[g], 32'd0);
      chk("async dz", g, 32'(dz_o[g]), 32'd0);
      chk("async ready", g, 32'(ready_o[g]), 32'd1);
    end
    @(negedge clk) rst_n = 1'b1;
    count_valid(40, cnt);
    for (int g = 0; g < ND; g++) chk("post reset no valid", g, cnt[g], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
